// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit character LCD controller: power-on init, byte FIFO, cursor tracking.
// Optional LCD_AUTOWRAP_EN: row wrap after the last column, and 0x0A acts as newline.
module lcd_text_ctrl #(
    parameter int CLK_MHZ    = 50,
    parameter int FIFO_DEPTH = 16,
    parameter int COLS       = 16,
    parameter int ROWS       = 2
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        in_cmd,
    output logic                        idle,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [5:0]                  cursor_col,
    output logic                        cursor_row,
    output logic                        LCD_E,
    output logic                        LCD_RS,
    output logic                        LCD_RW,
    output logic [3:0]                  SF_D,
    output logic                        SF_CE0
);
    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [31:0] cyc_of(input longint t_ns);
        longint v;
        v = (t_ns * longint'(CLK_MHZ) + longint'(999)) / longint'(1000);
        if (v < longint'(1)) v = longint'(1);
        return v[31:0];
    endfunction

    localparam logic [31:0] T_SU     = cyc_of(40);
    localparam logic [31:0] T_EH     = cyc_of(230);
    localparam logic [31:0] T_1US    = cyc_of(1000);
    localparam logic [31:0] T_40US   = cyc_of(40000);
    localparam logic [31:0] T_100US  = cyc_of(100000);
    localparam logic [31:0] T_4MS    = cyc_of(4100000);
    localparam logic [31:0] T_15MS   = cyc_of(15000000);
    localparam logic [31:0] T_164MS  = cyc_of(1640000);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);

    // Power-on sequence as {nibble_only, value}; nibble-only steps send value[3:0].
    function automatic logic [8:0] init_job(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: return 9'h103;
            4'd3:             return 9'h102;
            4'd4:             return 9'h028;
            4'd5:             return 9'h006;
            4'd6:             return 9'h00C;
            4'd7:             return 9'h001;
            default:          return 9'h080;
        endcase
    endfunction

    typedef enum logic [2:0] {ST_PWR, ST_SU, ST_EH, ST_WAIT, ST_IDLE} state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_cnt, w_wait_len;
    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_job_byte;
    logic          r_job_rs, r_job_nib, r_lo, r_init;
    logic [3:0]    r_init_idx;
    logic [5:0]    r_col;
    logic          r_row;
    logic          r_lcd_e, r_lcd_rs;
    logic [3:0]    r_sf_d;

    logic          w_push, w_pop, w_load, w_lo, w_done;
    logic [8:0]    w_head, w_init_job;
    logic [7:0]    w_ld_byte, w_wrap_addr;
    logic          w_ld_rs, w_ld_nib;
    logic [3:0]    w_ld_idx;

    assign in_ready    = (r_count < FULL_CNT);
    assign w_push      = in_valid && in_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_wrap_addr = (ROWS == 2 && !r_row) ? 8'hC0 : 8'h80;

    always_ff @(posedge Clock) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_cmd, in_data};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Wait following the nibble just strobed.
    always_comb begin
        w_wait_len = T_40US;
        if (r_job_nib) begin
            if (r_init_idx == 4'd0)      w_wait_len = T_4MS;
            else if (r_init_idx == 4'd1) w_wait_len = T_100US;
        end else if (!r_lo) begin
            w_wait_len = T_1US;
        end else if (!r_job_rs && (r_job_byte == 8'h01 || r_job_byte == 8'h02)) begin
            w_wait_len = T_164MS;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_load     = 1'b0;
        w_lo       = 1'b0;
        w_done     = 1'b0;
        w_ld_byte  = r_job_byte;
        w_ld_rs    = r_job_rs;
        w_ld_nib   = r_job_nib;
        w_ld_idx   = r_init_idx;
        w_init_job = init_job(r_init_idx + 4'd1);
        case (r_state)
            ST_PWR: begin
                if (r_cnt == T_15MS - 32'd1) begin
                    w_next   = ST_SU;
                    w_load   = 1'b1;
                    w_ld_idx = 4'd0;
                    w_ld_rs  = 1'b0;
                    {w_ld_nib, w_ld_byte} = init_job(4'd0);
                end
            end
            ST_SU:   if (r_cnt == T_SU - 32'd1) w_next = ST_EH;
            ST_EH:   if (r_cnt == T_EH - 32'd1) w_next = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == w_wait_len - 32'd1) begin
                    if (!r_job_nib && !r_lo) begin
                        w_next = ST_SU;
                        w_lo   = 1'b1;
                    end else begin
                        w_done = 1'b1;
                        if (r_init && r_init_idx != 4'd8) begin
                            w_next   = ST_SU;
                            w_load   = 1'b1;
                            w_ld_idx = r_init_idx + 4'd1;
                            w_ld_rs  = 1'b0;
                            {w_ld_nib, w_ld_byte} = w_init_job;
                        end
`ifdef LCD_AUTOWRAP_EN
                        else if (r_job_rs && r_col == LAST_COL) begin
                            w_next    = ST_SU;
                            w_load    = 1'b1;
                            w_ld_nib  = 1'b0;
                            w_ld_rs   = 1'b0;
                            w_ld_byte = w_wrap_addr;
                        end
`endif
                        else begin
                            w_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_next    = ST_SU;
                    w_load    = 1'b1;
                    w_ld_nib  = 1'b0;
                    w_ld_rs   = !w_head[8];
                    w_ld_byte = w_head[7:0];
`ifdef LCD_AUTOWRAP_EN
                    // Newline is never written; it becomes a set-DDRAM to the next row start.
                    if (!w_head[8] && w_head[7:0] == 8'h0A) begin
                        w_ld_rs   = 1'b0;
                        w_ld_byte = w_wrap_addr;
                    end
`endif
                end
            end
            default: w_next = ST_PWR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_PWR;
            r_cnt      <= '0;
            r_job_byte <= '0;
            r_job_rs   <= 1'b0;
            r_job_nib  <= 1'b0;
            r_lo       <= 1'b0;
            r_init     <= 1'b1;
            r_init_idx <= '0;
            r_col      <= '0;
            r_row      <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_sf_d     <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
            r_lcd_e <= (w_next == ST_EH);
            if (w_load) begin
                r_job_byte <= w_ld_byte;
                r_job_rs   <= w_ld_rs;
                r_job_nib  <= w_ld_nib;
                r_init_idx <= w_ld_idx;
                r_lo       <= 1'b0;
                r_lcd_rs   <= w_ld_rs;
                r_sf_d     <= w_ld_nib ? w_ld_byte[3:0] : w_ld_byte[7:4];
            end else if (w_lo) begin
                r_lo   <= 1'b1;
                r_sf_d <= r_job_byte[3:0];
            end
            if (w_done && r_init_idx == 4'd8) r_init <= 1'b0;
            if (w_done && !r_job_nib) begin
                if (r_job_rs) begin
                    r_col <= r_col + 6'd1;
                end else if (r_job_byte == 8'h01 || r_job_byte == 8'h02) begin
                    r_col <= '0;
                    r_row <= 1'b0;
                end else if (r_job_byte[7]) begin
                    r_row <= r_job_byte[6];
                    r_col <= r_job_byte[5:0];
                end
            end
        end
    end

    assign idle       = (r_state == ST_IDLE) && (r_count == '0);
    assign fifo_count = r_count;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign LCD_E      = r_lcd_e;
    assign LCD_RS     = r_lcd_rs;
    assign LCD_RW     = 1'b0;
    assign SF_D       = r_sf_d;
    assign SF_CE0     = 1'b1;
endmodule
